// File: rtl/sat_correlator.sv
// rtl/sat_correlator.sv - Doppler-wiped, C/A-wiped I/Q integrate-and-dump correlator
module sat_correlator #(
    parameter int INT_LEN = 2046,
    parameter int ACC_W   = 36
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    run,
    input  logic [31:0]             freq,
    input  logic [5:0]              ca_sel,
    input  logic [35:0]             ca_seq,
    input  logic                    epoch,
    input  logic signed [15:0]      real_in,
    input  logic signed [15:0]      imag_in,
    output logic signed [ACC_W-1:0] acc_i,
    output logic signed [ACC_W-1:0] acc_q,
    output logic                    dump_valid,
    input  logic                    dump_ready,
    output logic                    overrun,
    output logic [15:0]             dump_count
);
    localparam int CNT_W = (INT_LEN > 1) ? $clog2(INT_LEN) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_EPOCH, INTEGRATE} state_t;
    state_t state, state_next;

    logic [31:0]      phase;
    logic [CNT_W-1:0] cnt;
    logic             take, advance, last, ca_bit;
    logic signed [2:0] cos_k, sin_k;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE:       if (run) state_next = WAIT_EPOCH;
            WAIT_EPOCH: begin
                advance = enable;
                if (enable && epoch) begin
                    take       = 1'b1;
                    state_next = INTEGRATE;
                end
            end
            INTEGRATE: begin
                advance = enable;
                take    = enable;
            end
            default:    state_next = IDLE;
        endcase
        if (!run) begin
            state_next = IDLE;
            take       = 1'b0;
            advance    = 1'b0;
        end
    end

    assign last   = (cnt == CNT_W'(INT_LEN - 1));
    assign ca_bit = (ca_sel < 6'd36) ? ca_seq[ca_sel] : 1'b0;

    // Phase and sample count are held at zero in IDLE so WAIT_EPOCH always starts clean
    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE) begin
            phase <= '0;
            cnt   <= '0;
        end else begin
            if (advance) phase <= phase + freq;
            if (take)    cnt   <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    always_comb begin
        cos_k = 3'sd0;
        sin_k = 3'sd0;
        case (phase[31:29])
            3'd0: begin cos_k =  3'sd3; sin_k =  3'sd1; end
            3'd1: begin cos_k =  3'sd1; sin_k =  3'sd3; end
            3'd2: begin cos_k = -3'sd1; sin_k =  3'sd3; end
            3'd3: begin cos_k = -3'sd3; sin_k =  3'sd1; end
            3'd4: begin cos_k = -3'sd3; sin_k = -3'sd1; end
            3'd5: begin cos_k = -3'sd1; sin_k = -3'sd3; end
            3'd6: begin cos_k =  3'sd1; sin_k = -3'sd3; end
            default: begin cos_k = 3'sd3; sin_k = -3'sd1; end
        endcase
    end

    logic signed [15:0] re0, im0;
    logic signed [2:0]  cos0, sin0;
    logic               neg0, v0, last0, v1, last1;
    logic signed [18:0] re_x, im_x, c_x, s_x, i_mix, q_mix, i1, q1;
    logic signed [ACC_W-1:0] accum_i, accum_q, sum_i, sum_q;

    always_ff @(posedge clk) begin
        re0  <= real_in;
        im0  <= imag_in;
        cos0 <= cos_k;
        sin0 <= sin_k;
        neg0 <= ca_bit;
        i1   <= neg0 ? -i_mix : i_mix;
        q1   <= neg0 ? -q_mix : q_mix;
        if (!rst_n || !run) begin
            v0    <= 1'b0;
            last0 <= 1'b0;
            v1    <= 1'b0;
            last1 <= 1'b0;
        end else begin
            v0    <= take;
            last0 <= last;
            v1    <= v0;
            last1 <= last0;
        end
    end

    // Conjugate LO mix; 19 bits holds the worst case 2*32768*3 with either sign
    always_comb begin
        re_x  = {{3{re0[15]}}, re0};
        im_x  = {{3{im0[15]}}, im0};
        c_x   = {{16{cos0[2]}}, cos0};
        s_x   = {{16{sin0[2]}}, sin0};
        i_mix = re_x * c_x + im_x * s_x;
        q_mix = im_x * c_x - re_x * s_x;
    end

    assign sum_i = accum_i + {{(ACC_W-19){i1[18]}}, i1};
    assign sum_q = accum_q + {{(ACC_W-19){q1[18]}}, q1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            accum_i    <= '0;
            accum_q    <= '0;
            acc_i      <= '0;
            acc_q      <= '0;
            dump_valid <= 1'b0;
            overrun    <= 1'b0;
            dump_count <= '0;
        end else begin
            if (dump_valid && dump_ready) dump_valid <= 1'b0;
            if (!run) begin
                accum_i <= '0;
                accum_q <= '0;
                overrun <= 1'b0;
            end else if (v1) begin
                if (last1) begin
                    acc_i      <= sum_i;
                    acc_q      <= sum_q;
                    dump_valid <= 1'b1;
                    dump_count <= dump_count + 16'd1;
                    accum_i    <= '0;
                    accum_q    <= '0;
                    if (dump_valid && !dump_ready) overrun <= 1'b1;
                end else begin
                    accum_i <= sum_i;
                    accum_q <= sum_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_sat_correlator.sv
// tb/tb_sat_correlator.sv - directed self-checking bench for sat_correlator
module tb_sat_correlator;
    logic               clk = 1'b0;
    logic               rst_n, enable, run, epoch, dump_ready;
    logic [31:0]        freq;
    logic [5:0]         ca_sel;
    logic [35:0]        ca_seq;
    logic signed [15:0] real_in, imag_in;
    logic signed [35:0] acc_i, acc_q;
    logic               dump_valid, overrun;
    logic [15:0]        dump_count;
    int n_checks = 0;
    int n_fail   = 0;

    sat_correlator #(.INT_LEN(16), .ACC_W(36)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .run(run), .freq(freq),
        .ca_sel(ca_sel), .ca_seq(ca_seq), .epoch(epoch), .real_in(real_in),
        .imag_in(imag_in), .acc_i(acc_i), .acc_q(acc_q), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .overrun(overrun), .dump_count(dump_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n, input logic signed [15:0] re,
                          input logic signed [15:0] im, input logic first_epoch, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (gap) step();
            real_in = re;
            imag_in = im;
            epoch   = (i == 0) ? first_epoch : 1'b0;
            enable  = 1'b1;
            step();
            enable  = 1'b0;
            epoch   = 1'b0;
        end
    endtask

    task automatic restart();
        run = 1'b0;
        step();
        run = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; enable = 1'b0; epoch = 1'b0; dump_ready = 1'b1;
        freq = '0; ca_sel = '0; ca_seq = '0; real_in = '0; imag_in = '0;
        step(); step();
        n_checks++; if (acc_i !== 36'sd0) begin n_fail++; $display("FAIL reset_acc_i: got %0d expected 0", acc_i); end
        n_checks++; if (acc_q !== 36'sd0) begin n_fail++; $display("FAIL reset_acc_q: got %0d expected 0", acc_q); end
        n_checks++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", dump_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
        n_checks++; if (dump_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", dump_count); end
        rst_n = 1'b1; run = 1'b1;
        step();
    endtask

    task automatic test_basic();
        send_n(16, 16'sd1000, 16'sd0, 1'b1, 0);
        step();
        n_checks++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %0b expected 0", dump_valid); end
        step();
        n_checks++; if (dump_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b expected 1", dump_valid); end
        n_checks++; if (acc_i !== 36'sd48000) begin n_fail++; $display("FAIL basic_acc_i: got %0d expected 48000", acc_i); end
        n_checks++; if (acc_q !== -36'sd16000) begin n_fail++; $display("FAIL basic_acc_q: got %0d expected -16000", acc_q); end
        n_checks++; if (dump_count !== 16'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", dump_count); end
        step();
        n_checks++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %0b expected 0", dump_valid); end
    endtask

    task automatic test_ca();
        restart();
        ca_seq = 36'h0_0000_0020;
        ca_sel = 6'd5;
        send_n(16, 16'sd1000, 16'sd0, 1'b1, 0);
        ca_sel = 6'd6;
        step(); step();
        n_checks++; if (acc_i !== -36'sd48000) begin n_fail++; $display("FAIL ca_acc_i: got %0d expected -48000", acc_i); end
        n_checks++; if (acc_q !== 36'sd16000) begin n_fail++; $display("FAIL ca_acc_q: got %0d expected 16000", acc_q); end
        n_checks++; if (dump_count !== 16'd2) begin n_fail++; $display("FAIL ca_count: got %0d expected 2", dump_count); end
        send_n(16, 16'sd1000, 16'sd0, 1'b0, 0);
        step(); step();
        n_checks++; if (acc_i !== 36'sd48000) begin n_fail++; $display("FAIL ca_off_acc_i: got %0d expected 48000", acc_i); end
        n_checks++; if (acc_q !== -36'sd16000) begin n_fail++; $display("FAIL ca_off_acc_q: got %0d expected -16000", acc_q); end
        n_checks++; if (dump_count !== 16'd3) begin n_fail++; $display("FAIL ca_off_count: got %0d expected 3", dump_count); end
        ca_seq = '0;
    endtask

    task automatic test_nco();
        freq = 32'h2000_0000;
        restart();
        send_n(16, 16'sd1000, 16'sd0, 1'b1, 0);
        step(); step();
        n_checks++; if (acc_i !== 36'sd0) begin n_fail++; $display("FAIL nco_acc_i: got %0d expected 0", acc_i); end
        n_checks++; if (acc_q !== 36'sd0) begin n_fail++; $display("FAIL nco_acc_q: got %0d expected 0", acc_q); end
        n_checks++; if (dump_count !== 16'd4) begin n_fail++; $display("FAIL nco_count: got %0d expected 4", dump_count); end
        freq = '0;
    endtask

    task automatic test_back_to_back();
        restart();
        send_n(5, 16'sd5000, 16'sd0, 1'b0, 2);
        repeat (2) step();
        send_n(16, 16'sd1000, 16'sd0, 1'b1, 2);
        step(); step();
        n_checks++; if (acc_i !== 36'sd48000) begin n_fail++; $display("FAIL sparse1_acc_i: got %0d expected 48000", acc_i); end
        n_checks++; if (acc_q !== -36'sd16000) begin n_fail++; $display("FAIL sparse1_acc_q: got %0d expected -16000", acc_q); end
        n_checks++; if (dump_count !== 16'd5) begin n_fail++; $display("FAIL sparse1_count: got %0d expected 5", dump_count); end
        send_n(16, -16'sd2000, 16'sd500, 1'b1, 2);
        step(); step();
        n_checks++; if (acc_i !== -36'sd88000) begin n_fail++; $display("FAIL sparse2_acc_i: got %0d expected -88000", acc_i); end
        n_checks++; if (acc_q !== 36'sd56000) begin n_fail++; $display("FAIL sparse2_acc_q: got %0d expected 56000", acc_q); end
        n_checks++; if (dump_count !== 16'd6) begin n_fail++; $display("FAIL sparse2_count: got %0d expected 6", dump_count); end
    endtask

    task automatic test_overrun();
        restart();
        dump_ready = 1'b0;
        send_n(16, 16'sd1000, 16'sd0, 1'b1, 0);
        step(); step();
        n_checks++; if (dump_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %0b expected 1", dump_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first_flag: got %0b expected 0", overrun); end
        send_n(8, 16'sd2000, 16'sd0, 1'b0, 0);
        n_checks++; if (acc_i !== 36'sd48000) begin n_fail++; $display("FAIL ovr_stable: got %0d expected 48000", acc_i); end
        send_n(8, 16'sd2000, 16'sd0, 1'b0, 0);
        step(); step();
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %0b expected 1", overrun); end
        n_checks++; if (acc_i !== 36'sd96000) begin n_fail++; $display("FAIL ovr_acc_i: got %0d expected 96000", acc_i); end
        n_checks++; if (acc_q !== -36'sd32000) begin n_fail++; $display("FAIL ovr_acc_q: got %0d expected -32000", acc_q); end
        n_checks++; if (dump_count !== 16'd8) begin n_fail++; $display("FAIL ovr_count: got %0d expected 8", dump_count); end
        dump_ready = 1'b1;
        step();
        n_checks++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: got %0b expected 0", dump_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %0b expected 1", overrun); end
        restart();
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_run_clear: got %0b expected 0", overrun); end
    endtask

    task automatic test_reset_mid();
        send_n(8, 16'sd1000, 16'sd0, 1'b1, 0);
        rst_n = 1'b0;
        step();
        n_checks++; if (acc_i !== 36'sd0) begin n_fail++; $display("FAIL rmid_acc_i: got %0d expected 0", acc_i); end
        n_checks++; if (acc_q !== 36'sd0) begin n_fail++; $display("FAIL rmid_acc_q: got %0d expected 0", acc_q); end
        n_checks++; if (dump_count !== 16'd0) begin n_fail++; $display("FAIL rmid_count: got %0d expected 0", dump_count); end
        n_checks++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0b expected 0", dump_valid); end
        rst_n = 1'b1;
        step();
        send_n(8, 16'sd7000, 16'sd0, 1'b0, 0);
        send_n(16, -16'sd1000, 16'sd0, 1'b1, 0);
        step();
        n_checks++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_early: got %0b expected 0", dump_valid); end
        step();
        n_checks++; if (acc_i !== -36'sd48000) begin n_fail++; $display("FAIL rmid_post_acc_i: got %0d expected -48000", acc_i); end
        n_checks++; if (acc_q !== 36'sd16000) begin n_fail++; $display("FAIL rmid_post_acc_q: got %0d expected 16000", acc_q); end
        n_checks++; if (dump_count !== 16'd1) begin n_fail++; $display("FAIL rmid_post_count: got %0d expected 1", dump_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ca();
        test_nco();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
